// File: rtl/demux1to4_router.sv
// demux1to4_router: a one-entry registered buffer that steers one word to one of four
// valid/ready sinks, with a saturating transfer counter for each sink.
module demux1to4_router #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              cnt_clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_sel,
    input  logic [DATA_W-1:0] in_data,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [DATA_W-1:0] out_data0,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic [DATA_W-1:0] out_data3,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1,
    output logic [CNT_W-1:0]  cnt2,
    output logic [CNT_W-1:0]  cnt3,
    output logic              dbg_state_o
);

    // Handshake: a word moves on a rising edge where valid && ready are both high.
    // out_valid/out_data come from registers only, and the data is held while out_valid is high.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q [4];
    logic [CNT_W-1:0]  cnt_d [4];
    logic              hold_valid;
    logic              out_fire;
    logic              in_fire;

    assign hold_valid = (state_q == ST_FULL);
    assign out_fire   = hold_valid && out_ready[sel_q];
    assign in_ready   = !flush && (!hold_valid || out_ready[sel_q]);
    assign in_fire    = in_valid && in_ready;

    // A new word can replace one that drains in the same cycle; flush never coincides with in_fire.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        data_d  = data_q;
        if (in_fire) begin
            state_d = ST_FULL;
            sel_d   = in_sel;
            data_d  = in_data;
        end else if (flush || out_fire) begin
            state_d = ST_EMPTY;
        end
    end

    always_comb begin
        out_valid = 4'b0000;
        if (hold_valid) begin
            out_valid[sel_q] = 1'b1;
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            cnt_d[k] = cnt_q[k];
            if (cnt_clr) begin
                cnt_d[k] = '0;
            end else if (out_valid[k] && out_ready[k] && (cnt_q[k] != CNT_MAX)) begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            sel_q   <= 2'd0;
            data_q  <= '0;
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign out_data0   = out_valid[0] ? data_q : '0;
    assign out_data1   = out_valid[1] ? data_q : '0;
    assign out_data2   = out_valid[2] ? data_q : '0;
    assign out_data3   = out_valid[3] ? data_q : '0;
    assign cnt0        = cnt_q[0];
    assign cnt1        = cnt_q[1];
    assign cnt2        = cnt_q[2];
    assign cnt3        = cnt_q[3];
    assign dbg_state_o = (state_q == ST_FULL);

endmodule
